// File: rtl/bb_rst_pkg.sv
// Shared definitions for the target reset conditioning stage: reset-channel
// FSM state encoding and synchronizer depth.
package bb_rst_pkg;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } rst_state_e;

endpackage

// File: rtl/bb_target_reset_ctrl_if.sv
// Signal bundle between the FT2232 MPSSE side, the JTAG connector pins and
// the reset conditioning stage.
interface bb_target_reset_ctrl_if;

    logic FT_nSRST_OE;
    logic FT_nSRST_OUT;
    logic FT_nTRST_OE;
    logic FT_nTRST_OUT;
    logic nSRST_PIN;
    logic TARGET_PRESENT;
    logic nSRST_DRV;
    logic nTRST_DRV;
    logic FT_nSRST_IN;
    logic FT_TARGET_PRESENT;
    logic SRST_FAULT;

    modport master (
        output FT_nSRST_OE, FT_nSRST_OUT, FT_nTRST_OE, FT_nTRST_OUT,
        output nSRST_PIN, TARGET_PRESENT,
        input  nSRST_DRV, nTRST_DRV, FT_nSRST_IN, FT_TARGET_PRESENT, SRST_FAULT
    );

    modport slave (
        input  FT_nSRST_OE, FT_nSRST_OUT, FT_nTRST_OE, FT_nTRST_OUT,
        input  nSRST_PIN, TARGET_PRESENT,
        output nSRST_DRV, nTRST_DRV, FT_nSRST_IN, FT_TARGET_PRESENT, SRST_FAULT
    );

endinterface

// File: rtl/bb_rst_stretch.sv
// One reset channel: request synchronizer, minimum-width pulse stretcher and
// release wait (pin read-back with timeout, or fixed recovery time).
module bb_rst_stretch
    import bb_rst_pkg::*;
#(
    parameter int unsigned CNT_W           = 12,
    parameter int unsigned ASSERT_MIN_CYC  = 500,
    parameter int unsigned RELEASE_TMO_CYC = 4000,
    parameter int unsigned RECOVER_CYC     = 64,
    parameter bit          READBACK        = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_pin,
    output logic o_drv,
    output logic o_fault
);

    localparam logic [CNT_W-1:0] LP_ASSERT_LD = CNT_W'(ASSERT_MIN_CYC - 1);
    localparam logic [CNT_W-1:0] LP_REL_LAST  =
        CNT_W'((READBACK ? RELEASE_TMO_CYC : RECOVER_CYC) - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX   = '1;

    logic [SYNC_DEPTH-1:0] r_req_sync;
    rst_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_req;
    logic                  w_pin_hi;

    assign w_req    = r_req_sync[SYNC_DEPTH-1];
    assign w_pin_hi = READBACK && i_pin;

    // ASSERT counts down the minimum width; RELEASE counts up the wait.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_sync <= '0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            o_drv      <= 1'b0;
            o_fault    <= 1'b0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_DEPTH-2:0], i_req};
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= LP_ASSERT_LD;
                        o_drv   <= 1'b1;
                        o_fault <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt == '0) begin
                        if (w_req) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_RELEASE;
                            o_drv   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!w_req) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                        o_drv   <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (w_req) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= LP_ASSERT_LD;
                        o_drv   <= 1'b1;
                        o_fault <= 1'b0;
                    end else if (w_pin_hi) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= LP_REL_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        o_fault <= READBACK;
                    end else if (r_cnt != LP_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    o_drv   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bb_target_reset_ctrl.sv
// Target reset/presence conditioning: stretches FT nSRST/nTRST requests into
// open-drain pulls and debounces the nSRST read-back and TARGET_PRESENT.
// Define SRST_READBACK_EN to end the nSRST release on pin read-back with a
// timeout fault; otherwise nSRST uses a fixed recovery wait.
module bb_target_reset_ctrl
    import bb_rst_pkg::*;
#(
    parameter int unsigned ASSERT_MIN_CYC  = 500,
    parameter int unsigned DEBOUNCE_CYC    = 8,
    parameter int unsigned RELEASE_TMO_CYC = 4000,
    parameter int unsigned RECOVER_CYC     = 64,
    parameter int unsigned CNT_W           = 12
) (
    input  logic                 CLK,
    input  logic                 RST,
    bb_target_reset_ctrl_if.slave bus
);

`ifdef SRST_READBACK_EN
    localparam bit LP_SRST_RB = 1'b1;
`else
    localparam bit LP_SRST_RB = 1'b0;
`endif

    localparam int unsigned      LP_NDB      = 2;
    localparam logic [LP_NDB-1:0] LP_DB_RST  = 2'b01;
    localparam logic [CNT_W-1:0]  LP_DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic                  w_srst_req;
    logic                  w_trst_req;
    logic                  w_pin_sync;
    logic                  w_trst_fault_unused;
    logic [LP_NDB-1:0]     w_raw;
    logic [SYNC_DEPTH-1:0] r_db_sync [LP_NDB];
    logic [CNT_W-1:0]      r_db_cnt  [LP_NDB];
    logic [LP_NDB-1:0]     r_db_out;

    assign w_srst_req = bus.FT_nSRST_OE & ~bus.FT_nSRST_OUT;
    assign w_trst_req = bus.FT_nTRST_OE & ~bus.FT_nTRST_OUT;
    assign w_raw      = {bus.TARGET_PRESENT, bus.nSRST_PIN};
    assign w_pin_sync = r_db_sync[0][SYNC_DEPTH-1];

    bb_rst_stretch #(
        .CNT_W           (CNT_W),
        .ASSERT_MIN_CYC  (ASSERT_MIN_CYC),
        .RELEASE_TMO_CYC (RELEASE_TMO_CYC),
        .RECOVER_CYC     (RECOVER_CYC),
        .READBACK        (LP_SRST_RB)
    ) u_srst (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_req   (w_srst_req),
        .i_pin   (w_pin_sync),
        .o_drv   (bus.nSRST_DRV),
        .o_fault (bus.SRST_FAULT)
    );

    bb_rst_stretch #(
        .CNT_W           (CNT_W),
        .ASSERT_MIN_CYC  (ASSERT_MIN_CYC),
        .RELEASE_TMO_CYC (RELEASE_TMO_CYC),
        .RECOVER_CYC     (RECOVER_CYC),
        .READBACK        (1'b0)
    ) u_trst (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_req   (w_trst_req),
        .i_pin   (1'b0),
        .o_drv   (bus.nTRST_DRV),
        .o_fault (w_trst_fault_unused)
    );

    // Channel 0 = nSRST read-back (idles high), channel 1 = presence (idles low).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LP_NDB; i++) begin
                r_db_sync[i] <= {SYNC_DEPTH{LP_DB_RST[i]}};
                r_db_cnt[i]  <= '0;
            end
            r_db_out <= LP_DB_RST;
        end else begin
            for (int i = 0; i < LP_NDB; i++) begin
                r_db_sync[i] <= {r_db_sync[i][SYNC_DEPTH-2:0], w_raw[i]};
                if (r_db_sync[i][SYNC_DEPTH-1] == r_db_out[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] >= LP_DB_LAST) begin
                    r_db_out[i] <= ~r_db_out[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.FT_nSRST_IN       = r_db_out[0];
    assign bus.FT_TARGET_PRESENT = r_db_out[1];

endmodule

// File: tb/tb_bb_target_reset_ctrl.sv
// Self-checking bench for bb_target_reset_ctrl: directed scenarios plus
// randomized pulses and presence noise against a behavioural model.
module tb_bb_target_reset_ctrl;

    localparam int ASSERT_MIN = 500;
    localparam int DEB        = 8;
    localparam int TMO        = 4000;
    localparam int PIN_RISE   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bb_target_reset_ctrl_if ifc ();

    bb_target_reset_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (ifc)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   pin_stuck = 1'b0;
    bit   pres_rand = 1'b0;
    int   hi_cnt    = PIN_RISE;
    bit   hist_s[$];
    bit   hist_p[$];
    logic exp_s = 1'b1;
    logic exp_p = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Debounced level: the value the raw input held for DEB consecutive
    // samples, seen two samples late; q holds the last DEB+2 samples, oldest first.
    function automatic logic db_eval(input bit q[$], input logic cur);
        if (q.size() < DEB + 2) return cur;
        for (int k = 0; k < DEB; k++) if (q[k] == cur) return cur;
        return ~cur;
    endfunction

    task automatic step();
        @(posedge clk);
        hist_s.push_back(ifc.nSRST_PIN);
        hist_p.push_back(ifc.TARGET_PRESENT);
        if (hist_s.size() > DEB + 2) begin
            void'(hist_s.pop_front());
            void'(hist_p.pop_front());
        end
        #1;
        cyc++;
        exp_s = db_eval(hist_s, exp_s);
        exp_p = db_eval(hist_p, exp_p);
        chk("nsrst_in", ifc.FT_nSRST_IN, exp_s);
        chk("present", ifc.FT_TARGET_PRESENT, exp_p);
`ifndef SRST_READBACK_EN
        chk("fault_tied0", ifc.SRST_FAULT, 0);
`endif
        // Target: pin pulled low while driven, floats high PIN_RISE cycles later.
        if (pin_stuck || ifc.nSRST_DRV) begin
            ifc.nSRST_PIN = 1'b0;
            hi_cnt = 0;
        end else if (hi_cnt < PIN_RISE) begin
            hi_cnt++;
            if (hi_cnt == PIN_RISE) ifc.nSRST_PIN = 1'b1;
        end
        if (pres_rand && $urandom_range(5) == 0) ifc.TARGET_PRESENT = ~ifc.TARGET_PRESENT;
    endtask

    task automatic drive_req(input int ch, input bit on);
        logic oe, out;
        if (on) begin
            oe = 1'b1; out = 1'b0;
        end else if ($urandom_range(1) == 1) begin
            oe = 1'b0; out = 1'($urandom_range(1));
        end else begin
            oe = 1'b1; out = 1'b1;
        end
        if (ch == 0) begin
            ifc.FT_nSRST_OE = oe; ifc.FT_nSRST_OUT = out;
        end else begin
            ifc.FT_nTRST_OE = oe; ifc.FT_nTRST_OUT = out;
        end
    endtask

    function automatic logic drv(input int ch);
        return (ch == 0) ? ifc.nSRST_DRV : ifc.nTRST_DRV;
    endfunction

    // Request of len cycles; returns edge-to-DRV delay and DRV high width.
    task automatic run_pulse(input int ch, input int len, output int dly, output int width);
        int r, rise, fall;
        rise = -1; fall = -1;
        drive_req(ch, 1'b1);
        r = cyc;
        for (int k = 0; k < len + ASSERT_MIN + 100 && fall < 0; k++) begin
            step();
            if (cyc - r == len) drive_req(ch, 1'b0);
            if (rise < 0 && drv(ch)) rise = cyc;
            else if (rise >= 0 && fall < 0 && !drv(ch)) fall = cyc;
        end
        drive_req(ch, 1'b0);
        dly   = (rise < 0) ? -1 : rise - r;
        width = (rise < 0 || fall < 0) ? -1 : fall - rise;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_nsrst_drv"}, ifc.nSRST_DRV, 0);
        chk({tag, "_ntrst_drv"}, ifc.nTRST_DRV, 0);
        chk({tag, "_nsrst_in"}, ifc.FT_nSRST_IN, 1);
        chk({tag, "_present"}, ifc.FT_TARGET_PRESENT, 0);
        chk({tag, "_fault"}, ifc.SRST_FAULT, 0);
    endtask

    task automatic model_reset();
        hist_s.delete();
        hist_p.delete();
        exp_s = 1'b1;
        exp_p = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, w, f, r, tf, len, ch;
        bit rose;
        ifc.FT_nSRST_OE = 1'b0; ifc.FT_nSRST_OUT = 1'b1;
        ifc.FT_nTRST_OE = 1'b0; ifc.FT_nTRST_OUT = 1'b1;
        ifc.nSRST_PIN = 1'b1;
        ifc.TARGET_PRESENT = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst = 1'b0;
        model_reset();
        repeat (10) step();

        // Short SRST request: exact minimum width, clean release.
        run_pulse(0, 10, d, w);
        chk("srst10_dly", d, 3);
        chk("srst10_width", w, ASSERT_MIN);
        repeat (40) step();
        chk("srst10_fault", ifc.SRST_FAULT, 0);

        // Long SRST request: width follows the request.
        run_pulse(0, 2000, d, w);
        chk("srst2000_dly", d, 3);
        chk("srst2000_width", w, 2000);
        repeat (40) step();

        // Pin stuck low after release.
        pin_stuck = 1'b1;
        run_pulse(0, 10, d, w);
        chk("stuck_width", w, ASSERT_MIN);
`ifdef SRST_READBACK_EN
        f = cyc; tf = -1;
        for (int k = 0; k < TMO + 100 && tf < 0; k++) begin
            step();
            if (ifc.SRST_FAULT) tf = cyc - f;
        end
        chk("tmo_window", 32'((tf >= TMO) && (tf <= TMO + 1)), 1);
        pin_stuck = 1'b0;
        repeat (40) step();
        chk("fault_sticky", ifc.SRST_FAULT, 1);
        drive_req(0, 1'b1);
        r = cyc; rose = 1'b0;
        for (int k = 0; k < 10 && !rose; k++) begin
            step();
            if (cyc - r == 2) chk("fault_before_assert", ifc.SRST_FAULT, 1);
            if (ifc.nSRST_DRV) begin
                rose = 1'b1;
                chk("fault_cleared", ifc.SRST_FAULT, 0);
                chk("refault_dly", cyc - r, 3);
            end
        end
        chk("refault_rose", 32'(rose), 1);
        repeat (10) step();
        drive_req(0, 1'b0);
        for (int k = 0; k < ASSERT_MIN + 20 && ifc.nSRST_DRV; k++) step();
        chk("refault_released", ifc.nSRST_DRV, 0);
`else
        repeat (TMO + 50) step();
        chk("no_fault_wo_readback", ifc.SRST_FAULT, 0);
        pin_stuck = 1'b0;
`endif
        repeat (40) step();

        // Presence glitches of 5 cycles, then a stable edge.
        ifc.TARGET_PRESENT = 1'b0;
        repeat (20) step();
        for (int g = 0; g < 3; g++) begin
            ifc.TARGET_PRESENT = 1'b1;
            repeat (5) step();
            ifc.TARGET_PRESENT = 1'b0;
            repeat (10) step();
        end
        chk("glitch_filtered", ifc.FT_TARGET_PRESENT, 0);
        ifc.TARGET_PRESENT = 1'b1;
        r = cyc; tf = -1;
        for (int k = 0; k < 30 && tf < 0; k++) begin
            step();
            if (ifc.FT_TARGET_PRESENT) tf = cyc - r;
        end
        chk("present_latency", tf, 2 + DEB);

        // Re-request in the fifth cycle of RELEASE on both channels.
        for (int c = 0; c < 2; c++) begin
            run_pulse(c, 10, d, w);
            step();
            step();
            run_pulse(c, 10, d, w);
            chk("rereq_dly", d, 3);
            chk("rereq_width", w, ASSERT_MIN);
            repeat (100) step();
        end

        // Boundary lengths around the minimum, then random pulses with presence noise.
        for (int i = 0; i < 15; i++) begin
            if (i < 3) begin
                ch = 1; len = ASSERT_MIN - 1 + i;
            end else begin
                ch = $urandom_range(1); len = $urandom_range(700, 1);
                pres_rand = 1'b1;
            end
            run_pulse(ch, len, d, w);
            chk("rand_dly", d, 3);
            chk("rand_width", w, (len > ASSERT_MIN) ? len : ASSERT_MIN);
            repeat ($urandom_range(100, 1)) step();
        end
        pres_rand = 1'b0;
        repeat (40) step();

        // Asynchronous reset 200 cycles into an nTRST pulse.
        drive_req(1, 1'b1);
        for (int k = 0; k < 10 && !ifc.nTRST_DRV; k++) step();
        chk("pre_rst_trst_high", ifc.nTRST_DRV, 1);
        repeat (200) step();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        drive_req(1, 1'b0);
        ifc.TARGET_PRESENT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("held_rst");
        rst = 1'b0;
        model_reset();
        repeat (30) step();
        run_pulse(1, 10, d, w);
        chk("post_rst_dly", d, 3);
        chk("post_rst_width", w, ASSERT_MIN);
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bb_target_reset_ctrl.md
# bb_target_reset_ctrl

Target-side reset and presence conditioning stage between the FT2232 MPSSE control outputs and the JTAG connector pins. It stretches FT-requested nSRST/nTRST pulses to a guaranteed minimum width and drives the pins open-drain. It debounces the nSRST read-back and TARGET_PRESENT before they are returned to the FT2232. Its outputs feed the pin-level passthrough, which only wires signals.

## Interface
- ASSERT_MIN_CYC, 500: minimum cycles a reset line is driven low once requested.
- DEBOUNCE_CYC, 8: consecutive stable cycles required before a debounced output changes.
- RELEASE_TMO_CYC, 4000: maximum cycles to wait for nSRST to read high after release.
- RECOVER_CYC, 64: fixed post-release wait, used only when read-back is compiled out.
- CNT_W, 12: counter width. Every count parameter must be in the range 1..2^CNT_W-1.

Ports:
- CLK  in  1  single system clock.
- RST  in  1  reset, asynchronous, active-high.
- FT_nSRST_OE  in  1  FT enables the nSRST output.
- FT_nSRST_OUT  in  1  FT nSRST level.
- FT_nTRST_OE  in  1  FT enables the nTRST output.
- FT_nTRST_OUT  in  1  FT nTRST level.
- nSRST_PIN  in  1  raw nSRST pin read-back.
- TARGET_PRESENT  in  1  raw target-present pin.
- nSRST_DRV  out  1  1 = pull nSRST low; the top level releases the pin to Z when 0.
- nTRST_DRV  out  1  1 = pull nTRST low.
- FT_nSRST_IN  out  1  debounced nSRST level.
- FT_TARGET_PRESENT  out  1  debounced presence.
- SRST_FAULT  out  1  sticky: nSRST failed to rise within RELEASE_TMO_CYC.

## Operation
- Request definitions:
  - SRST request = FT_nSRST_OE & ~FT_nSRST_OUT.
  - TRST request = FT_nTRST_OE & ~FT_nTRST_OUT.
  - Each request passes through a 2-FF synchronizer.
- Each reset channel has an independent FSM:
  - IDLE: DRV=0. Synced request=1 -> ASSERT, counter loaded with ASSERT_MIN_CYC-1.
  - ASSERT: DRV=1. Counter decrements each cycle and request changes are ignored. At counter=0, go to HOLD if request=1, otherwise go to RELEASE.
  - HOLD: DRV=1. Request=0 -> RELEASE.
  - RELEASE: DRV=0. Exit conditions, first match wins:
    - Request=1 -> ASSERT, counter reloaded. This takes priority over all other exits.
    - Synced pin=1 -> IDLE.
    - Counter reaches RELEASE_TMO_CYC -> IDLE and set SRST_FAULT.
  - The nTRST channel has no read-back. It waits RECOVER_CYC in RELEASE, then goes to IDLE.
- SRST_FAULT clears on the next SRST entry to ASSERT.
- Debouncers for nSRST_PIN and TARGET_PRESENT:
  - Input passes through a 2-FF synchronizer.
  - The stability counter resets whenever the synced input equals the output.
  - The output toggles when the counter reaches DEBOUNCE_CYC-1 with the input still differing.
  - A glitch shorter than DEBOUNCE_CYC cycles never reaches the output.
- During self-driven assertion, FT_nSRST_IN follows the pin and shows 0 after debounce. This is intended.

## Timing
- Reset values:
  - nSRST_DRV=0, nTRST_DRV=0.
  - FT_nSRST_IN=1, FT_TARGET_PRESENT=0, SRST_FAULT=0.
  - All FSMs in IDLE, all counters 0.
- RST takes effect immediately, asynchronously. Asserting RST mid-pulse releases DRV in the same instant. There is no minimum-width guarantee across reset.
- Request edge to DRV=1: 3 CLK rising edges (2 synchronizer + 1 FSM register).
- The DRV=1 width is at least ASSERT_MIN_CYC cycles. It equals exactly ASSERT_MIN_CYC when the request is shorter than ASSERT_MIN_CYC.
- Pin change to debounced output change: 2 + DEBOUNCE_CYC cycles.
- Request deassert and counter=0 in the same cycle: go to RELEASE.
- Request reassert in the same cycle as pin-high in RELEASE: go to ASSERT.
- Counters saturate and never wrap.

## Configuration
- SRST_READBACK_EN defined:
  - SRST RELEASE waits for the synced pin to be high, bounded by the timeout.
  - SRST_FAULT is functional.
- SRST_READBACK_EN undefined:
  - SRST RELEASE behaves like nTRST: a fixed RECOVER_CYC wait.
  - SRST_FAULT is tied to 0.
  - RELEASE_TMO_CYC is unused.
  - The nSRST_PIN debouncer remains present.

## Structure
- Shared package bb_rst_pkg holds:
  - FSM state encodings: IDLE=2'd0, ASSERT=2'd1, HOLD=2'd2, RELEASE=2'd3.
  - The synchronizer depth constant (2).
- One sub-module, bb_rst_stretch: one synchronizer, FSM and counter per channel, with a READBACK parameter. It is instantiated twice: SRST with READBACK following the macro, TRST with READBACK=0.
- The debouncers are inline in the top level.

## Test plan
- SRST request of 10 cycles, defaults -> nSRST_DRV rises 3 cycles after the edge and stays high for exactly 500 cycles. Pin model pulls high 20 cycles after release -> IDLE, SRST_FAULT=0.
- SRST request held for 2000 cycles -> DRV high for 2000 cycles ±1, then RELEASE.
- Pin held low after release (SRST_READBACK_EN defined) -> IDLE after 4000 cycles, SRST_FAULT=1. A new request clears SRST_FAULT in ASSERT.
- TARGET_PRESENT glitches of 5 cycles high, then a stable high -> FT_TARGET_PRESENT stays 0 during the glitches and rises 10 cycles after the stable edge.
- RST pulse at cycle 200 of an nTRST assertion -> nTRST_DRV=0 immediately and all outputs return to their reset values.
- Request reasserted in cycle 5 of RELEASE -> back to ASSERT with a full 500-cycle minimum.
